// File: rtl/mod_counter_param.sv
// Runtime-programmable modulo-M up/down counter with deferred modulus update and registered tc.
// Optional prescaler compiled in with `define MOD_COUNTER_PRESCALE_EN.
module mod_counter_param #(
    parameter int BITS        = 4,
    parameter int MOD_DEFAULT = 10,
    parameter int PRE_DIV     = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            clear,
    input  logic            load,
    input  logic [BITS-1:0] load_val,
    input  logic            up_down,
    input  logic            mod_we,
    input  logic [BITS-1:0] mod_val,
    output logic [BITS-1:0] Q,
    output logic            done,
    output logic            tc,
    output logic [BITS-1:0] mod_active
);

    if (PRE_DIV < 1) begin : g_bad_pre_div
        $error("PRE_DIV must be at least 1");
    end

    localparam logic [BITS-1:0] MOD_RST = BITS'(MOD_DEFAULT);
    localparam logic [BITS:0]   ONE_EXT = (BITS+1)'(1);

    logic [BITS-1:0] ma;
    logic [BITS-1:0] mp;
    logic            pv;

    logic [BITS-1:0] ma_apply;
    logic [BITS:0]   em_m1;
    logic [BITS:0]   apply_m1;
    logic [BITS-1:0] load_q;
    logic            at_top;
    logic            at_zero;
    logic            step;
    logic            wrap;

    // Terminal value of a modulus; a code of 0 stands for 2^BITS, hence the extra bit.
    function automatic logic [BITS:0] term_of(input logic [BITS-1:0] m);
        logic [BITS:0] e;
        e = (m == '0) ? {1'b1, {BITS{1'b0}}} : {1'b0, m};
        return e - ONE_EXT;
    endfunction

    assign ma_apply   = pv ? mp : ma;
    assign em_m1      = term_of(ma);
    assign apply_m1   = term_of(ma_apply);
    assign load_q     = ({1'b0, load_val} > apply_m1) ? apply_m1[BITS-1:0] : load_val;
    assign at_top     = ({1'b0, Q} == em_m1);
    assign at_zero    = (Q == '0);
    assign done       = up_down ? at_top : at_zero;
    assign wrap       = step && done;
    assign mod_active = ma;

`ifdef MOD_COUNTER_PRESCALE_EN
    localparam int PW = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

    logic [PW-1:0] pre_cnt;
    logic          pre_term;

    assign pre_term = (pre_cnt == PW'(PRE_DIV - 1));
    assign step     = enable && !clear && !load && pre_term;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (clear || load) begin
            pre_cnt <= '0;
        end else if (enable) begin
            pre_cnt <= pre_term ? '0 : pre_cnt + PW'(1);
        end
    end
`else
    assign step = enable && !clear && !load;
`endif

    // NOTE: non-blocking assignments throughout, so every right-hand side sees pre-edge state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Q  <= '0;
            ma <= MOD_RST;
            mp <= MOD_RST;
            pv <= 1'b0;
            tc <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (clear) begin
                Q  <= '0;
                ma <= ma_apply;
                pv <= 1'b0;
            end else if (load) begin
                Q  <= load_q;
                ma <= ma_apply;
                pv <= 1'b0;
            end else if (step) begin
                if (wrap) begin
                    tc <= 1'b1;
                    ma <= ma_apply;
                    pv <= 1'b0;
                    Q  <= up_down ? '0 : apply_m1[BITS-1:0];
                end else begin
                    Q <= up_down ? Q + BITS'(1) : Q - BITS'(1);
                end
            end
            // NOTE: placed last so a coinciding write overrides the pv clear above and stays pending.
            if (mod_we) begin
                mp <= mod_val;
                pv <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mod_counter_param.md
# mod_counter_param

Runtime-programmable modulo-M up/down counter. It is the parametrised successor to the fixed modulo-8 counter used across the design's timer and sequencer paths. It adds the following:
- configurable width and reset modulus
- a modulus change that is safely deferred to the next wrap
- synchronous clear and load
- a direction control
- a registered terminal-count pulse for cascading stages

## Interface
- BITS, 4, counter and modulus width.
- MOD_DEFAULT, 10, modulus loaded at reset. Legal range is 0 to 2^BITS-1, where 0 encodes 2^BITS.
- PRE_DIV, 4, prescale ratio, ≥1. Used only when MOD_COUNTER_PRESCALE_EN is defined.
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  count-step qualifier.
- clear  input  1  synchronous clear to 0.
- load  input  1  synchronous load of load_val.
- load_val  input  BITS  value for load.
- up_down  input  1  1 = count up, 0 = count down. Sampled every step.
- mod_we  input  1  write mod_val into the pending-modulus register.
- mod_val  input  BITS  new modulus M. 0 means 2^BITS.
- Q  output  BITS  count value, registered.
- done  output  1  combinational. Q is at the terminal state for the current direction: M-1 when up, 0 when down.
- tc  output  1  registered one-cycle pulse, high the cycle after a wrap step.
- mod_active  output  BITS  modulus currently in force.

## Operation
- State held in registers:
  - Q
  - active modulus MA
  - pending modulus MP with a pending flag PV
  - tc
  - the prescaler, when it is compiled in
- Effective modulus: EM = (MA==0) ? 2^BITS : MA. All arithmetic is BITS+1 wide internally so that EM-1 never overflows.
- Priority per cycle is clear > load > step. mod_we is independent of this priority.
- clear:
  - Sets Q=0.
  - If PV=1, sets MA=MP and PV=0.
  - Resets the prescaler.
  - Sets tc=0.
  - Ignores enable.
- load:
  - If PV=1, first applies MP to MA.
  - Sets Q = min(load_val, EM'-1), where EM' is the effective modulus after that update.
  - Resets the prescaler.
  - Sets tc=0.
- step occurs when enable=1 and neither clear nor load is asserted. With the prescaler compiled in, a step also requires the prescaler to be at terminal.
  - Up, Q≠EM-1: Q+1.
  - Up, Q=EM-1: wrap to 0.
  - Down, Q≠0: Q-1.
  - Down, Q=0: wrap to EMn-1, where EMn is the modulus in force after the wrap.
- Wrap step:
  - If PV=1, sets MA=MP and PV=0 in the same edge.
  - tc is 1 on the next cycle.
- Any non-wrap cycle sets tc=0.
- mod_we:
  - Sets MP=mod_val and PV=1.
  - If it coincides with a wrap, clear or load, the new value becomes pending and is not applied that edge. The older MP is applied.
  - Back-to-back writes: last write wins.
- M=1: Q stays 0, every step is a wrap, and tc is high continuously while stepping.
- Q is never outside 0..EM-1, because MA changes only together with wrap, clear or load.
- Without enable, Q and MA hold.

## Timing
- Reset values are asynchronous on reset_n low:
  - Q=0
  - tc=0
  - MA=MP=MOD_DEFAULT
  - PV=0
  - prescaler=0
- done therefore resets to 1 if up_down=0, or if MOD_DEFAULT=1.
- Reset deasserted mid-count restarts from these values. No partial state is retained.
- Latency:
  - Q updates one clk after the qualifying edge.
  - tc follows Q's wrap value in the same cycle, one clock after the wrap step's edge.
  - done is zero-latency from Q and up_down.
- Cascading: connect an upper stage's enable to a lower stage's tc to get a single-step carry.

## Configuration
- MOD_COUNTER_PRESCALE_EN defined:
  - An internal counter 0..PRE_DIV-1 advances on every enable=1 cycle.
  - A step occurs only on the enabled cycle where the prescaler is PRE_DIV-1, after which the prescaler returns to 0.
  - Clear and load reset the prescaler.
  - PRE_DIV=1 is equivalent to no prescaler.
- Not defined:
  - No prescaler logic is present.
  - Every enable=1 cycle is a step.
  - PRE_DIV is ignored.

## Test plan
- Reset, BITS=4, MOD_DEFAULT=10, up, enable held high → Q runs 0..9,0. tc is high only in the cycle where Q=0 after 9. mod_active=10.
- Down counting from reset with M=10 → Q runs 0,9,8,…,0,9. done is high at Q=0. tc pulses after each 0→9 wrap.
- mod_we mod_val=5 at Q=3 (up) → Q continues 4..9,0 under M=10, then 0..4 under M=5. mod_active changes to 5 exactly at the wrap edge.
- load load_val=12 with M=10 → Q=9. Load together with clear → Q=0. mod_val=0 with BITS=4, then clear → counts 0..15.
- M=1, enable high → Q stays 0 and tc stays high. Assert reset_n low mid-count at Q=6 → Q=0, tc=0, mod_active=MOD_DEFAULT immediately.
- With MOD_COUNTER_PRESCALE_EN and PRE_DIV=4, enable high → Q increments every 4th cycle. A load resets the phase, so the next step comes 4 enabled cycles after the load.
